// File: rtl/duck_sprite_fetch.sv
// Duck sprite fetch: bounding-box hit test, sprite-ROM addressing with
// animation frame and horizontal flip, and ROM-aligned palette index output.
//
// Ports:
//   vga_clk      pixel clock, all logic on the rising edge
//   Reset        asynchronous, active-high
//   DrawX/DrawY  current pixel column/row from the VGA counter
//   blank_n      1 = active video
//   frame_start  1-cycle pulse at start of vertical blank
//   duck_x/y     sprite top-left; sampled on frame_start
//   duck_alive   enables wing-flap animation; evaluated on frame_start
//   duck_flip    1 = mirror horizontally; sampled on frame_start
//   rom_addr     sprite-ROM address (registered)
//   rom_q        sprite-ROM data, valid ROM_LAT cycles after rom_addr
//   pix_index    palette index to the palette LUT (registered)
//   pix_valid    1 = opaque duck pixel (registered)
//   anim_frame   current animation frame, 0..FRAMES-1
//
// Optional feature: define DUCK_SPRITE_DBG_BOX_EN to draw a black
// (index 1) outline on the sprite bounding box regardless of rom_q.
//
// Latency from DrawX to pix_index/pix_valid is ROM_LAT+2 cycles.

module duck_sprite_fetch #(
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int FRAMES     = 3,
  parameter int FRAME_DIV  = 8,
  parameter int ROM_LAT    = 1,
  parameter int ADDR_W     = 12,
  parameter int TRANSP_IDX = 0
) (
  input  logic              vga_clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank_n,
  input  logic              frame_start,
  input  logic [9:0]        duck_x,
  input  logic [9:0]        duck_y,
  input  logic              duck_alive,
  input  logic              duck_flip,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        pix_index,
  output logic              pix_valid,
  output logic [1:0]        anim_frame
);

  localparam int XB       = $clog2(SPR_W);
  localparam int YB       = $clog2(SPR_H);
  localparam int FRAME_SZ = SPR_W * SPR_H;
  localparam int DB       = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam logic [DB-1:0] DIV_LAST  = DB'(FRAME_DIV - 1);
  localparam logic [1:0]    FRM_LAST  = 2'(FRAMES - 1);
  localparam logic [3:0]    TRANSP    = 4'(TRANSP_IDX);
  localparam logic [10:0]   W11       = 11'(SPR_W);
  localparam logic [10:0]   H11       = 11'(SPR_H);

  // ------------------------------------------------------------------
  // Per-frame latched sprite state
  // ------------------------------------------------------------------
  logic [9:0]    lx;
  logic [9:0]    ly;
  logic          lflip;
  logic [DB-1:0] div_cnt;

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      lx    <= '0;
      ly    <= '0;
      lflip <= 1'b0;
    end else if (frame_start) begin
      lx    <= duck_x;
      ly    <= duck_y;
      lflip <= duck_flip;
    end
  end

  // Wing-flap animation: advances one frame every FRAME_DIV
  // frame_start pulses while alive; a dead duck snaps to frame 0.
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      div_cnt    <= '0;
      anim_frame <= '0;
    end else if (frame_start) begin
      if (duck_alive) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          if (anim_frame == FRM_LAST)
            anim_frame <= '0;
          else
            anim_frame <= anim_frame + 2'd1;
        end else begin
          div_cnt <= div_cnt + DB'(1);
        end
      end else begin
        div_cnt    <= '0;
        anim_frame <= '0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Hit test (11-bit so a box near the right edge never wraps to x=0)
  // ------------------------------------------------------------------
  logic [10:0] x11;
  logic [10:0] y11;
  logic [10:0] lx11;
  logic [10:0] ly11;
  logic        in_x;
  logic        in_y;
  logic        hit;

  assign x11  = {1'b0, DrawX};
  assign y11  = {1'b0, DrawY};
  assign lx11 = {1'b0, lx};
  assign ly11 = {1'b0, ly};

  assign in_x = (x11 >= lx11) && (x11 < lx11 + W11);
  assign in_y = (y11 >= ly11) && (y11 < ly11 + H11);
  assign hit  = in_x && in_y && blank_n;

  // ------------------------------------------------------------------
  // Address generation
  // ------------------------------------------------------------------
  // Only the low bits of the offsets matter inside the box, and the low
  // bits of a difference depend only on the low bits of its operands.
  logic [XB-1:0]     dx;
  logic [YB-1:0]     dy;
  logic [XB-1:0]     col;
  logic [ADDR_W-1:0] frame_base;
  logic [ADDR_W-1:0] addr_next;

  assign dx = DrawX[XB-1:0] - lx[XB-1:0];
  assign dy = DrawY[YB-1:0] - ly[YB-1:0];

  // SPR_W-1-dx equals ~dx for a power-of-two width.
  assign col = lflip ? ~dx : dx;

  assign frame_base = ADDR_W'(anim_frame) * ADDR_W'(FRAME_SZ);
  assign addr_next  = frame_base + ADDR_W'({dy, col});

  // Address holds outside the box to keep the ROM bus quiet.
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset)
      rom_addr <= '0;
    else if (hit)
      rom_addr <= addr_next;
  end

  // ------------------------------------------------------------------
  // Hit pipeline: one stage for the address register plus ROM_LAT
  // stages for the ROM read, so hit_d lines up with rom_q.
  // ------------------------------------------------------------------
  logic [ROM_LAT:0] hit_sr;
  logic             hit_d;

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset)
      hit_sr <= '0;
    else
      hit_sr <= {hit_sr[ROM_LAT-1:0], hit};
  end

  assign hit_d = hit_sr[ROM_LAT];

`ifdef DUCK_SPRITE_DBG_BOX_EN
  logic             border;
  logic [ROM_LAT:0] brd_sr;
  logic             brd_d;

  assign border = (dx == '0) || (dx == '1) ||
                  (dy == '0) || (dy == '1);

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset)
      brd_sr <= '0;
    else
      brd_sr <= {brd_sr[ROM_LAT-1:0], border};
  end

  assign brd_d = brd_sr[ROM_LAT];
`endif

  // ------------------------------------------------------------------
  // Output stage
  // ------------------------------------------------------------------
  logic       valid_next;
  logic [3:0] index_next;

  always_comb begin
    valid_next = hit_d && (rom_q != TRANSP);
    index_next = valid_next ? rom_q : 4'd0;
`ifdef DUCK_SPRITE_DBG_BOX_EN
    // Outline is drawn black even over transparent ROM texels.
    if (hit_d && brd_d) begin
      valid_next = 1'b1;
      index_next = 4'd1;
    end
`endif
  end

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      pix_valid <= 1'b0;
      pix_index <= '0;
    end else begin
      pix_valid <= valid_next;
      pix_index <= index_next;
    end
  end

endmodule

// File: tb/tb_duck_sprite_fetch.sv
// Self-checking bench for duck_sprite_fetch: directed table, corner
// sequences and randomized traffic against a pixel-level reference model.

module tb_duck_sprite_fetch;

  logic        vga_clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank_n;
  logic        frame_start;
  logic [9:0]  duck_x;
  logic [9:0]  duck_y;
  logic        duck_alive;
  logic        duck_flip;
  logic [11:0] rom_addr;
  logic [3:0]  rom_q = 4'd0;
  logic [3:0]  pix_index;
  logic        pix_valid;
  logic [1:0]  anim_frame;

  always #5 vga_clk = ~vga_clk;

  duck_sprite_fetch dut (
    .vga_clk     (vga_clk),
    .Reset       (Reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank_n     (blank_n),
    .frame_start (frame_start),
    .duck_x      (duck_x),
    .duck_y      (duck_y),
    .duck_alive  (duck_alive),
    .duck_flip   (duck_flip),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .pix_index   (pix_index),
    .pix_valid   (pix_valid),
    .anim_frame  (anim_frame)
  );

  // Sprite ROM with 1-cycle read latency
  logic [3:0] rom_mem [0:4095];
  always @(posedge vga_clk) rom_q <= rom_mem[rom_addr];

`ifdef DUCK_SPRITE_DBG_BOX_EN
  localparam int BIDX = 1;
  localparam int ROW55_CNT = 2;
`else
  localparam int BIDX = 3;
  localparam int ROW55_CNT = 0;
`endif

  int ntests = 0;
  int nfail  = 0;
  int vcount = 0;

  // Reference model state
  int m_lx, m_ly, m_flip, m_af, m_div, m_addr;

  typedef struct {
    bit v;
    int idx;
  } exp_t;
  exp_t q[$];

  typedef struct {
    int x;
    int y;
    bit blank;
    bit ev;
    int eidx;
    int eaddr;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(string name, int act, int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_lx = 0; m_ly = 0; m_flip = 0;
    m_af = 0; m_div = 0; m_addr = 0;
    q.delete();
    q.push_back('{v: 1'b0, idx: 0});
    q.push_back('{v: 1'b0, idx: 0});
  endtask

  // Drive one pixel at the falling edge, predict, then check outputs
  // one falling edge later.
  task automatic cycle(int x, int y, bit blank, bit fs);
    exp_t e;
    exp_t o;
    int dx, dy, col, a;
    bit hit;
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    blank_n     = blank;
    frame_start = fs;
    e.v = 1'b0;
    e.idx = 0;
    hit = blank && x >= m_lx && x < m_lx + 32 &&
          y >= m_ly && y < m_ly + 32;
    if (hit) begin
      dx = x - m_lx;
      dy = y - m_ly;
      col = m_flip ? 31 - dx : dx;
      a = m_af * 1024 + dy * 32 + col;
      m_addr = a;
      if (rom_mem[a] != 4'd0) begin
        e.v = 1'b1;
        e.idx = int'(rom_mem[a]);
      end
`ifdef DUCK_SPRITE_DBG_BOX_EN
      if (dx == 0 || dx == 31 || dy == 0 || dy == 31) begin
        e.v = 1'b1;
        e.idx = 1;
      end
`endif
    end
    if (fs) begin
      m_lx = int'(duck_x);
      m_ly = int'(duck_y);
      m_flip = int'(duck_flip);
      if (duck_alive) begin
        if (m_div == 7) begin
          m_div = 0;
          m_af = (m_af + 1) % 3;
        end else begin
          m_div++;
        end
      end else begin
        m_div = 0;
        m_af = 0;
      end
    end
    q.push_back(e);
    @(negedge vga_clk);
    chk("sb_rom_addr", int'(rom_addr), m_addr);
    chk("sb_anim_frame", int'(anim_frame), m_af);
    if (q.size() == 3) begin
      o = q.pop_front();
      chk("sb_pix_valid", int'(pix_valid), int'(o.v));
      chk("sb_pix_index", int'(pix_index), o.idx);
    end
    if (pix_valid) vcount++;
  endtask

  task automatic idle();
    cycle(700, 500, 1'b0, 1'b0);
  endtask

  task automatic flush();
    repeat (3) idle();
  endtask

  task automatic fill(int val);
    for (int i = 0; i < 4096; i++)
      rom_mem[i] = (val < 0) ? 4'($urandom_range(0, 15)) : 4'(val);
  endtask

  task automatic scan_row(int y, int x0, int x1);
    for (int x = x0; x <= x1; x++) cycle(x, y, 1'b1, 1'b0);
    flush();
  endtask

  task automatic do_reset();
    #2 Reset = 1'b1;
    #1;
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_pix_index", int'(pix_index), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_anim_frame", int'(anim_frame), 0);
    @(negedge vga_clk);
    Reset = 1'b0;
    model_reset();
  endtask

  initial begin
    tbl[0] = '{x: 100, y: 50, blank: 1, ev: 1, eidx: BIDX, eaddr: 0};
    tbl[1] = '{x: 131, y: 50, blank: 1, ev: 1, eidx: BIDX, eaddr: 31};
    tbl[2] = '{x: 99,  y: 50, blank: 1, ev: 0, eidx: 0, eaddr: 31};
    tbl[3] = '{x: 132, y: 50, blank: 1, ev: 0, eidx: 0, eaddr: 31};
    tbl[4] = '{x: 110, y: 51, blank: 1, ev: 1, eidx: 3, eaddr: 42};
    tbl[5] = '{x: 100, y: 81, blank: 1, ev: 1, eidx: BIDX, eaddr: 992};
    tbl[6] = '{x: 100, y: 82, blank: 1, ev: 0, eidx: 0, eaddr: 992};
    tbl[7] = '{x: 105, y: 49, blank: 1, ev: 0, eidx: 0, eaddr: 992};
    tbl[8] = '{x: 120, y: 60, blank: 0, ev: 0, eidx: 0, eaddr: 992};

    Reset = 1'b1;
    DrawX = 10'd700;
    DrawY = 10'd500;
    blank_n = 1'b0;
    frame_start = 1'b0;
    duck_x = '0;
    duck_y = '0;
    duck_alive = 1'b0;
    duck_flip = 1'b0;
    fill(0);
    @(negedge vga_clk);
    @(negedge vga_clk);
    chk("init_pix_valid", int'(pix_valid), 0);
    chk("init_pix_index", int'(pix_index), 0);
    chk("init_rom_addr", int'(rom_addr), 0);
    chk("init_anim_frame", int'(anim_frame), 0);
    Reset = 1'b0;
    model_reset();

    // Basic box on row 50
    duck_x = 10'd100;
    duck_y = 10'd50;
    flush();
    fill(3);
    cycle(700, 500, 1'b0, 1'b1);
    vcount = 0;
    scan_row(50, 0, 200);
    chk("row50_count", vcount, 32);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].x, tbl[i].y, tbl[i].blank, 1'b0);
      chk("tbl_rom_addr", int'(rom_addr), tbl[i].eaddr);
      idle();
      idle();
      chk("tbl_pix_valid", int'(pix_valid), int'(tbl[i].ev));
      chk("tbl_pix_index", int'(pix_index), tbl[i].eidx);
    end

    // Transparency
    flush();
    fill(0);
    vcount = 0;
    scan_row(55, 0, 200);
    chk("transp_count", vcount, ROW55_CNT);
    fill(4);
    cycle(110, 55, 1'b1, 1'b0);
    chk("idx4_addr", int'(rom_addr), 170);
    idle();
    idle();
    chk("idx4_valid", int'(pix_valid), 1);
    chk("idx4_index", int'(pix_index), 4);

    // Animation
    duck_alive = 1'b1;
    for (int p = 1; p <= 24; p++) begin
      cycle(700, 500, 1'b0, 1'b1);
      if (p == 8)  chk("anim_p8", int'(anim_frame), 1);
      if (p == 16) chk("anim_p16", int'(anim_frame), 2);
      if (p == 24) chk("anim_p24", int'(anim_frame), 0);
    end
    repeat (8) cycle(700, 500, 1'b0, 1'b1);
    cycle(100, 50, 1'b1, 1'b0);
    chk("frame1_addr", int'(rom_addr), 1024);
    duck_alive = 1'b0;
    cycle(700, 500, 1'b0, 1'b1);
    chk("dead_anim", int'(anim_frame), 0);

    // Reset while drawing
    flush();
    fill(3);
    duck_alive = 1'b1;
    repeat (8) cycle(700, 500, 1'b0, 1'b1);
    for (int x = 100; x <= 104; x++) cycle(x, 50, 1'b1, 1'b0);
    chk("pre_reset_valid", int'(pix_valid), 1);
    chk("pre_reset_anim", int'(anim_frame), 1);
    do_reset();
    cycle(0, 0, 1'b1, 1'b0);
    idle();
    chk("post_rst_valid_l2", int'(pix_valid), 0);
    idle();
    chk("post_rst_valid_l3", int'(pix_valid), 1);
    chk("post_rst_index_l3", int'(pix_index), BIDX);
    flush();

    // Flip and mid-frame position change
    duck_alive = 1'b0;
    duck_flip = 1'b1;
    duck_x = 10'd100;
    duck_y = 10'd50;
    cycle(700, 500, 1'b0, 1'b1);
    cycle(100, 52, 1'b1, 1'b0);
    chk("flip_addr", int'(rom_addr), 95);
    duck_x = 10'd200;
    cycle(101, 52, 1'b1, 1'b0);
    chk("stale_x_addr", int'(rom_addr), 94);
    cycle(200, 52, 1'b1, 1'b0);
    chk("stale_x_hold", int'(rom_addr), 94);
    flush();

    // Right-edge box never aliases to the left
    duck_flip = 1'b0;
    duck_x = 10'd1020;
    cycle(700, 500, 1'b0, 1'b1);
    vcount = 0;
    scan_row(50, 0, 639);
    chk("edge_count", vcount, 0);

`ifdef DUCK_SPRITE_DBG_BOX_EN
    fill(0);
    duck_x = 10'd100;
    cycle(700, 500, 1'b0, 1'b1);
    cycle(100, 60, 1'b1, 1'b0);
    idle();
    idle();
    chk("box_valid", int'(pix_valid), 1);
    chk("box_index", int'(pix_index), 1);
    flush();
`endif

    // Randomized traffic
    fill(-1);
    for (int n = 0; n < 4000; n++) begin
      int x, y;
      bit fs;
      fs = ($urandom_range(0, 199) == 0);
      if (fs) begin
        case ($urandom_range(0, 2))
          0: duck_x = 10'($urandom_range(0, 1023));
          1: duck_x = 10'($urandom_range(990, 1023));
          default: duck_x = 10'($urandom_range(0, 639));
        endcase
        duck_y = 10'($urandom_range(0, 1023));
        duck_alive = ($urandom_range(0, 3) != 0);
        duck_flip = 1'($urandom_range(0, 1));
      end
      x = (m_lx - 5 + int'($urandom_range(0, 41)) + 1024) % 1024;
      y = (m_ly - 3 + int'($urandom_range(0, 37)) + 1024) % 1024;
      if ($urandom_range(0, 9) == 0) x = int'($urandom_range(0, 1023));
      cycle(x, y, ($urandom_range(0, 9) != 0), fs);
    end
    flush();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
